clock_set_controller: RTL and testbench
=======================================

Name: clock_set_controller

Overview:
- Front-panel sequencer for the digital clock's time-set datapath. It turns two raw push-buttons (MODE, ADJ) into the datapath's clock_set_select[1:0] field selector and set_confirm increment pulse.
- Adds debounce, hold-to-auto-repeat, an inactivity timeout back to run mode, and a blink flag for the display driver.
- Sits between the board buttons and the hour/minute/second counter block. It runs on the same single clock; all timing except debounce is counted in tick enables.

Parameters:
- DEB_CYCLES, 4: clk cycles a synchronized button must hold a new level before the debounced level changes.
- REPEAT_DELAY, 8: ticks ADJ must be held before auto-repeat starts.
- REPEAT_RATE, 2: ticks between auto-repeat pulses.
- TIMEOUT, 30: ticks with no debounced press in a set state before returning to RUN.
- BLINK_HALF, 1: ticks per blink half-period.

Ports:
- clk  in  1  system clock; every register is on its rising edge.
- cr  in  1  reset, synchronous, active-high.
- tick  in  1  one-cycle timebase enable (nominally 2 Hz).
- btn_mode  in  1  raw MODE button, asynchronous, active-high.
- btn_adj  in  1  raw ADJ button, asynchronous, active-high.
- clock_set_select  out  2  00 run, 01 seconds, 10 minutes, 11 hours.
- set_confirm  out  1  one-cycle increment/commit pulse for the selected field.
- setting  out  1  high in any set state.
- blink  out  1  display blank flag for the selected field; 0 in RUN.

Behaviour:
- Interface (already decided): one clock, clk. Reset cr is synchronous and active-high. All outputs are registered.
- Reset (cr=1 at a clk edge): state=RUN, clock_set_select=00, set_confirm=0, setting=0, blink=0. All counters and debounced levels are cleared to 0. Reset is effective mid-press or mid-repeat.
- Input conditioning:
  - Each raw button passes through a 2-FF synchronizer.
  - The debounced level takes the synchronized value after that value has differed from it for DEB_CYCLES consecutive clks. A glitch shorter than this resets the count.
  - A press event is a one-clk 0->1 edge of the debounced level.
- FSM states: RUN(00), SET_SEC(01), SET_MIN(10), SET_HOUR(11). The encoding equals clock_set_select.
  - MODE press: RUN->SET_SEC->SET_MIN->SET_HOUR->RUN.
  - Timeout in any set state: next state is RUN.
  - The state register drives clock_set_select directly, so select changes 1 clk after the press event.
- set_confirm:
  - ADJ press event in a set state: set_confirm=1 on the following clk, for exactly 1 clk.
  - ADJ in RUN is ignored: no pulse, no state change.
- Auto-repeat:
  - While debounced ADJ stays high in a set state, a hold counter increments on each tick.
  - After REPEAT_DELAY ticks, emit one set_confirm, then one more every REPEAT_RATE ticks.
  - The counter clears on ADJ release, on a state change, and on reset.
- Simultaneous MODE and ADJ press events in the same clk: MODE wins, the ADJ event is discarded, and no set_confirm is issued.
- set_confirm is never high in the same cycle that clock_set_select changes. An auto-repeat pulse due on a mode-change clk is suppressed.
- Timeout:
  - The idle counter increments on tick in set states and clears on any press event or auto-repeat pulse.
  - When it reaches TIMEOUT, the next clk goes to RUN with no set_confirm.
  - The counter is held at 0 in RUN.
- blink:
  - Toggles every BLINK_HALF ticks in set states.
  - Forced to 0 in RUN, and forced to 1 on entry to a set state so the field is visibly selected.
  - Held at 1 while ADJ is held down, so the value being changed stays visible.
- Counter widths: wide enough for the parameter maximum, using $clog2(param+1). No wrap occurs before the compare fires.

Decomposition:
- Shared package clock_ctrl_pkg holds the state/select encoding constants SEL_RUN=2'b00, SEL_SEC=2'b01, SEL_MIN=2'b10, SEL_HOUR=2'b11.
- Sub-module button_debounce (parameter DEB_CYCLES; ports clk, cr, raw, level, press) holds the synchronizer, debounce counter and edge detector. It is instantiated twice.
- FSM, repeat, timeout and blink logic stay in the top module.

Test Plan:
- All runs use DEB_CYCLES=3, REPEAT_DELAY=4, REPEAT_RATE=2, TIMEOUT=6, BLINK_HALF=1, with tick every 4 clks.
- Reset and press timing: assert cr for 2 clks -> select=00, set_confirm=0, blink=0. Then hold btn_mode high 10 clks -> select=01 exactly 2+3+1 clks after the rising edge. setting=1 and blink=1 on entry.
- Mode cycle and ADJ in RUN: four clean MODE presses -> select steps 01,10,11,00. An ADJ press in RUN -> no set_confirm.
- Glitch rejection: btn_adj high for 2 clks in SET_MIN -> no set_confirm, and the idle counter is not cleared.
- Auto-repeat: in SET_HOUR hold ADJ for 12 ticks -> 1 immediate pulse, then pulses at ticks 4, 6, 8, 10, 12. Each pulse is exactly 1 clk wide, and blink stays 1 while ADJ is held.
- Simultaneous press and timeout:
  - MODE and ADJ debounced on the same clk in SET_SEC -> select=10 and no set_confirm.
  - Then idle for 6 ticks -> select=00, setting=0, blink=0.
- Mid-operation reset: assert cr during an ADJ hold in SET_MIN -> select=00 next clk. No further set_confirm while ADJ stays held.

Source files
------------

// File: rtl/clock_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : clock_ctrl_pkg
// Description : Shared select/state encoding for the clock time-set front panel.
//               The FSM state encoding is identical to clock_set_select.
// Revision    : 1.0 - initial release
// ============================================================================
package clock_ctrl_pkg;

  localparam logic [1:0] SEL_RUN  = 2'b00;
  localparam logic [1:0] SEL_SEC  = 2'b01;
  localparam logic [1:0] SEL_MIN  = 2'b10;
  localparam logic [1:0] SEL_HOUR = 2'b11;

  typedef enum logic [1:0] {
    ST_RUN  = SEL_RUN,
    ST_SEC  = SEL_SEC,
    ST_MIN  = SEL_MIN,
    ST_HOUR = SEL_HOUR
  } state_e;

  // MODE steps RUN -> SEC -> MIN -> HOUR -> RUN
  function automatic state_e next_field(input state_e s);
    case (s)
      ST_RUN:  return ST_SEC;
      ST_SEC:  return ST_MIN;
      ST_MIN:  return ST_HOUR;
      default: return ST_RUN;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/button_debounce.sv
`default_nettype none
// ============================================================================
// Module      : button_debounce
// Description : 2-FF synchronizer, level debouncer and rising-edge detector for
//               one raw push-button. level follows the synchronized input once
//               it has differed for DEB_CYCLES consecutive clocks; press pulses
//               for one clock on the same edge that level rises.
// Revision    : 1.0 - initial release
// ============================================================================
module button_debounce #(
  parameter int DEB_CYCLES = 4
) (
  input  logic clk,
  input  logic cr,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam int CNT_W = $clog2(DEB_CYCLES + 1);

  logic             r_sync1;
  logic             r_sync2;
  logic [CNT_W-1:0] r_cnt;

  // Synchronize, count consecutive disagreeing clocks, update level and flag rises
  always_ff @(posedge clk) begin
    if (cr) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_cnt   <= '0;
      level   <= 1'b0;
      press   <= 1'b0;
    end else begin
      r_sync1 <= raw;
      r_sync2 <= r_sync1;
      press   <= 1'b0;
      if (r_sync2 != level) begin
        if (r_cnt == CNT_W'(DEB_CYCLES - 1)) begin
          level <= r_sync2;
          press <= r_sync2;
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end else begin
        // Any return to the current level restarts the qualification window
        r_cnt <= '0;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/clock_set_controller.sv
`default_nettype none
// ============================================================================
// Module      : clock_set_controller
// Description : Front-panel sequencer for the time-set datapath. Debounces MODE
//               and ADJ, walks the field selector, issues increment pulses with
//               hold-to-repeat, times out back to RUN and drives a blink flag.
// Revision    : 1.0 - initial release
// ============================================================================
module clock_set_controller
  import clock_ctrl_pkg::*;
#(
  parameter int DEB_CYCLES   = 4,
  parameter int REPEAT_DELAY = 8,
  parameter int REPEAT_RATE  = 2,
  parameter int TIMEOUT      = 30,
  parameter int BLINK_HALF   = 1
) (
  input  logic       clk,
  input  logic       cr,
  input  logic       tick,
  input  logic       btn_mode,
  input  logic       btn_adj,
  output logic [1:0] clock_set_select,
  output logic       set_confirm,
  output logic       setting,
  output logic       blink
);

  localparam int HOLD_W  = $clog2(REPEAT_DELAY + 1);
  localparam int RATE_W  = $clog2(REPEAT_RATE + 1);
  localparam int IDLE_W  = $clog2(TIMEOUT + 1);
  localparam int BLINK_W = $clog2(BLINK_HALF + 1);

  state_e              r_state;
  logic [HOLD_W-1:0]   r_hold;
  logic                r_rep_active;
  logic [RATE_W-1:0]   r_rate;
  logic [IDLE_W-1:0]   r_idle;
  logic [BLINK_W-1:0]  r_blink_cnt;

  logic   w_mode_press;
  logic   w_adj_press;
  logic   w_adj_level;
  logic   w_unused_mode_level;  // MODE acts only on its press edge
  logic   w_in_set;
  logic   w_timeout;
  logic   w_mode_change;
  logic   w_rep_due;
  logic   w_rep_pulse;
  state_e w_next_state;

  button_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_mode (
    .clk   (clk),
    .cr    (cr),
    .raw   (btn_mode),
    .level (w_unused_mode_level),
    .press (w_mode_press)
  );

  button_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_adj (
    .clk   (clk),
    .cr    (cr),
    .raw   (btn_adj),
    .level (w_adj_level),
    .press (w_adj_press)
  );

  // Select follows the state register directly
  assign clock_set_select = r_state;

  // Decode state transitions and the auto-repeat due condition
  always_comb begin
    w_in_set      = (r_state != ST_RUN);
    w_timeout     = w_in_set && (r_idle == IDLE_W'(TIMEOUT));
    w_mode_change = w_mode_press || w_timeout;
    if (w_mode_press) begin
      w_next_state = next_field(r_state);
    end else begin
      w_next_state = ST_RUN;
    end
    // First repeat after REPEAT_DELAY held ticks, then every REPEAT_RATE ticks
    if (r_rep_active) begin
      w_rep_due = (r_rate == RATE_W'(REPEAT_RATE - 1));
    end else begin
      w_rep_due = (r_hold == HOLD_W'(REPEAT_DELAY - 1));
    end
    w_rep_pulse = w_in_set && w_adj_level && tick && w_rep_due;
  end

  // FSM with registered outputs; a mode change pre-empts any ADJ or repeat pulse
  always_ff @(posedge clk) begin
    if (cr) begin
      r_state      <= ST_RUN;
      set_confirm  <= 1'b0;
      setting      <= 1'b0;
      blink        <= 1'b0;
      r_hold       <= '0;
      r_rep_active <= 1'b0;
      r_rate       <= '0;
      r_idle       <= '0;
      r_blink_cnt  <= '0;
    end else begin
      set_confirm <= 1'b0;
      if (w_mode_change) begin
        r_state      <= w_next_state;
        setting      <= (w_next_state != ST_RUN);
        // Entering a set field shows it immediately; RUN never blinks
        blink        <= (w_next_state != ST_RUN);
        r_hold       <= '0;
        r_rep_active <= 1'b0;
        r_rate       <= '0;
        r_idle       <= '0;
        r_blink_cnt  <= '0;
      end else if (!w_in_set) begin
        // RUN: ADJ is ignored and every set-mode counter stays parked
        setting      <= 1'b0;
        blink        <= 1'b0;
        r_hold       <= '0;
        r_rep_active <= 1'b0;
        r_rate       <= '0;
        r_idle       <= '0;
        r_blink_cnt  <= '0;
      end else begin
        set_confirm <= w_adj_press || w_rep_pulse;

        // Inactivity: any increment counts as activity
        if (w_adj_press || w_rep_pulse) begin
          r_idle <= '0;
        end else if (tick) begin
          r_idle <= r_idle + IDLE_W'(1);
        end

        // Hold-to-repeat timing
        if (!w_adj_level) begin
          r_hold       <= '0;
          r_rep_active <= 1'b0;
          r_rate       <= '0;
        end else if (tick) begin
          if (r_rep_active) begin
            r_rate <= w_rep_due ? '0 : r_rate + RATE_W'(1);
          end else if (w_rep_due) begin
            r_rep_active <= 1'b1;
            r_rate       <= '0;
          end else begin
            r_hold <= r_hold + HOLD_W'(1);
          end
        end

        // Blink; held on while ADJ is down so the changing value stays visible
        if (w_adj_level) begin
          blink       <= 1'b1;
          r_blink_cnt <= '0;
        end else if (tick) begin
          if (r_blink_cnt == BLINK_W'(BLINK_HALF - 1)) begin
            blink       <= ~blink;
            r_blink_cnt <= '0;
          end else begin
            r_blink_cnt <= r_blink_cnt + BLINK_W'(1);
          end
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_clock_set_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_clock_set_controller
// Description : Self-checking bench for clock_set_controller: directed vector
//               table for the mode walk plus hand sequences for press latency,
//               glitch rejection, auto-repeat, simultaneous press, timeout and
//               mid-operation reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_clock_set_controller;

  logic       clk;
  logic       cr;
  logic       tick;
  logic       btn_mode;
  logic       btn_adj;
  logic [1:0] clock_set_select;
  logic       set_confirm;
  logic       setting;
  logic       blink;

  int checks     = 0;
  int failures   = 0;
  int pulse_cnt  = 0;
  int cycle_n    = 0;
  bit last_tick  = 1'b0;

  clock_set_controller #(
    .DEB_CYCLES   (3),
    .REPEAT_DELAY (4),
    .REPEAT_RATE  (2),
    .TIMEOUT      (6),
    .BLINK_HALF   (1)
  ) dut (
    .clk              (clk),
    .cr               (cr),
    .tick             (tick),
    .btn_mode         (btn_mode),
    .btn_adj          (btn_adj),
    .clock_set_select (clock_set_select),
    .set_confirm      (set_confirm),
    .setting          (setting),
    .blink            (blink)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    bit         mode;
    bit         adj;
    int         ncyc;
    logic [1:0] sel;
    bit         setting;
    int         pulses;
    bit         chk_blink;
    bit         blink;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, exp, cycle_n);
    end
  endtask

  // One clock: remember the tick the DUT samples, advance, sample outputs,
  // then schedule the next tick (one every 4 clocks)
  task automatic cyc();
    logic [1:0] prev_sel;
    prev_sel  = clock_set_select;
    last_tick = tick;
    @(posedge clk);
    #1;
    cycle_n++;
    tick = (cycle_n % 4 == 0);
    if (set_confirm === 1'b1) pulse_cnt++;
    if (clock_set_select !== prev_sel && prev_sel !== 2'bxx)
      check("no_confirm_on_select_change", int'(set_confirm), 0);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) cyc();
  endtask

  // Press MODE (optionally with ADJ), expect the select change 6 clocks later
  task automatic mode_press_wait(input logic [1:0] exp_sel, input bit with_adj);
    logic [1:0] s0;
    int n;
    int p0;
    s0 = clock_set_select;
    n  = 0;
    p0 = pulse_cnt;
    btn_mode = 1'b1;
    btn_adj  = with_adj;
    while (clock_set_select == s0 && n < 20) begin
      cyc();
      n++;
    end
    check("mode_press_sel", int'(clock_set_select), int'(exp_sel));
    check("mode_press_latency", n, 6);
    check("mode_press_no_confirm", pulse_cnt - p0, 0);
    btn_mode = 1'b0;
    btn_adj  = 1'b0;
  endtask

  // Idle counter was cleared on the last edge; RUN must follow the 6th tick
  task automatic expect_timeout(input bit glitch, input string tag);
    logic [1:0] s0;
    int nt;
    int g;
    int guard;
    int p0;
    s0 = clock_set_select;
    nt = 0;
    g = 0;
    guard = 0;
    p0 = pulse_cnt;
    while (nt < 6 && guard < 200) begin
      if (glitch && nt >= 2 && g < 2) begin
        btn_adj = 1'b1;
        g++;
      end else begin
        btn_adj = 1'b0;
      end
      cyc();
      guard++;
      if (last_tick) nt++;
    end
    check({tag, "_ticks_seen"}, nt, 6);
    check({tag, "_not_early"}, int'(clock_set_select), int'(s0));
    check({tag, "_no_confirm"}, pulse_cnt - p0, 0);
    cyc();
    check({tag, "_sel_run"}, int'(clock_set_select), 0);
    check({tag, "_setting"}, int'(setting), 0);
    check({tag, "_blink"}, int'(blink), 0);
  endtask

  vec_t vecs[10];

  initial begin
    int p0;
    int e;
    int rel;
    int tc;
    int n;
    bit seen;
    bit exp_p;

    vecs[0] = '{1'b1, 1'b0, 4, 2'b01, 1'b1, 0, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 1'b0, 8, 2'b01, 1'b1, 0, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 8, 2'b10, 1'b1, 0, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 1'b0, 8, 2'b10, 1'b1, 0, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 1'b0, 8, 2'b11, 1'b1, 0, 1'b0, 1'b0};
    vecs[5] = '{1'b0, 1'b0, 8, 2'b11, 1'b1, 0, 1'b0, 1'b0};
    vecs[6] = '{1'b1, 1'b0, 8, 2'b00, 1'b0, 0, 1'b1, 1'b0};
    vecs[7] = '{1'b0, 1'b0, 8, 2'b00, 1'b0, 0, 1'b1, 1'b0};
    vecs[8] = '{1'b0, 1'b1, 8, 2'b00, 1'b0, 0, 1'b1, 1'b0};
    vecs[9] = '{1'b0, 1'b0, 8, 2'b00, 1'b0, 0, 1'b1, 1'b0};

    cr = 1'b1;
    tick = 1'b0;
    btn_mode = 1'b0;
    btn_adj = 1'b0;

    // Reset state, then MODE press latency 2 sync + 3 debounce + 1 FSM
    wait_cycles(2);
    check("reset_sel", int'(clock_set_select), 0);
    check("reset_confirm", int'(set_confirm), 0);
    check("reset_setting", int'(setting), 0);
    check("reset_blink", int'(blink), 0);
    cr = 1'b0;
    btn_mode = 1'b1;
    wait_cycles(5);
    check("press_latency_early", int'(clock_set_select), 0);
    cyc();
    check("press_latency_sel", int'(clock_set_select), 1);
    check("entry_setting", int'(setting), 1);
    check("entry_blink", int'(blink), 1);

    // Mode walk and ADJ in RUN
    for (int i = 0; i < 10; i++) begin
      btn_mode = vecs[i].mode;
      btn_adj  = vecs[i].adj;
      p0 = pulse_cnt;
      wait_cycles(vecs[i].ncyc);
      check($sformatf("vec%0d_sel", i), int'(clock_set_select), int'(vecs[i].sel));
      check($sformatf("vec%0d_setting", i), int'(setting), int'(vecs[i].setting));
      check($sformatf("vec%0d_pulses", i), pulse_cnt - p0, vecs[i].pulses);
      if (vecs[i].chk_blink)
        check($sformatf("vec%0d_blink", i), int'(blink), int'(vecs[i].blink));
    end

    // Glitch in SET_MIN: no confirm and the idle count keeps running
    mode_press_wait(2'b01, 1'b0);
    wait_cycles(8);
    mode_press_wait(2'b10, 1'b0);
    expect_timeout(1'b1, "glitch_timeout");
    wait_cycles(8);

    // Auto-repeat in SET_HOUR
    mode_press_wait(2'b01, 1'b0);
    wait_cycles(8);
    mode_press_wait(2'b10, 1'b0);
    wait_cycles(8);
    mode_press_wait(2'b11, 1'b0);
    wait_cycles(8);
    btn_adj = 1'b1;
    p0 = pulse_cnt;
    e = 0;
    rel = 0;
    tc = 0;
    while (e < 200) begin
      cyc();
      e++;
      seen = (e >= 6) && (rel == 0 || e <= rel + 5);
      if (seen && last_tick) tc++;
      exp_p = (e == 6) || (seen && last_tick && tc >= 4 && (tc % 2) == 0);
      check("repeat_pulse", int'(set_confirm), int'(exp_p));
      if (seen) check("repeat_blink_held", int'(blink), 1);
      if (rel == 0 && tc == 12 && last_tick) begin
        btn_adj = 1'b0;
        rel = e;
      end
      if (rel != 0 && e >= rel + 10) break;
    end
    check("repeat_hold_released", int'(rel != 0), 1);
    check("repeat_pulse_total", pulse_cnt - p0, 6);
    check("repeat_sel_kept", int'(clock_set_select), 3);

    // Simultaneous MODE+ADJ in SET_SEC, then timeout to RUN
    mode_press_wait(2'b00, 1'b0);
    wait_cycles(8);
    mode_press_wait(2'b01, 1'b0);
    wait_cycles(8);
    mode_press_wait(2'b10, 1'b1);
    expect_timeout(1'b0, "simul_timeout");
    wait_cycles(8);

    // Reset in the middle of an ADJ hold in SET_MIN
    mode_press_wait(2'b01, 1'b0);
    wait_cycles(8);
    mode_press_wait(2'b10, 1'b0);
    wait_cycles(8);
    btn_adj = 1'b1;
    p0 = pulse_cnt;
    n = 0;
    while (pulse_cnt == p0 && n < 20) begin
      cyc();
      n++;
    end
    check("midreset_first_pulse", pulse_cnt - p0, 1);
    wait_cycles(6);
    cr = 1'b1;
    cyc();
    check("midreset_sel", int'(clock_set_select), 0);
    check("midreset_setting", int'(setting), 0);
    check("midreset_blink", int'(blink), 0);
    check("midreset_confirm", int'(set_confirm), 0);
    cr = 1'b0;
    p0 = pulse_cnt;
    wait_cycles(24);
    check("midreset_no_pulse", pulse_cnt - p0, 0);
    check("midreset_sel_run", int'(clock_set_select), 0);
    btn_adj = 1'b0;
    wait_cycles(8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
